// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use hazard controller beside the ID stage. Keeps its own pipeline of
// in-flight destination tags and decodes per-source forward selects, stall and a stall counter.
module hazard_forward_ctrl #(
   parameter int AW         = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 3,
   parameter int LOAD_READY = 2,
   parameter int SW         = $clog2(FWD_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [NUM_SRC*AW-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]    id_src_used,
   input  logic [AW-1:0]         id_dst_addr,
   input  logic                  id_regwr,
   input  logic                  id_is_load,
   input  logic                  id_flush,
   input  logic                  pipe_hold,
   output logic [NUM_SRC*SW-1:0] fwd_sel,
   output logic                  stall,
   output logic [15:0]           stall_count
);

   // Tag stage k describes the instruction whose result is on stage k's result bus.
   logic [FWD_DEPTH:1] tag_v;
   logic [FWD_DEPTH:1] tag_ld;
   logic [AW-1:0]      tag_addr [1:FWD_DEPTH];

   logic [FWD_DEPTH:1] match [NUM_SRC];
   logic [NUM_SRC-1:0] src_hazard;
   logic               issue;
   logic               advance;

   assign advance = !pipe_hold;
   assign issue   = id_valid && !id_flush && !stall && id_regwr && (id_dst_addr != '0);

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         match[i] = '0;
         for (int k = 1; k <= FWD_DEPTH; k++) begin
            match[i][k] = id_src_used[i] && tag_v[k]
                          && (tag_addr[k] == id_src_addr[i*AW +: AW])
                          && (id_src_addr[i*AW +: AW] != '0);
         end
      end
   end

   // Oldest-to-youngest scan: the last hit written is the youngest producer.
   always_comb begin
      // NOTE: outputs get defaults before the scan so no path leaves them unassigned (no latch).
      fwd_sel    = '0;
      src_hazard = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (match[i][k]) begin
               fwd_sel[i*SW +: SW] = SW'(k);
               src_hazard[i]       = tag_ld[k] && (k < LOAD_READY);
            end
         end
      end
   end

   assign stall = id_valid && !id_flush && (|src_hazard);

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so each stage shifts in its neighbour's pre-edge value.
      if (reset) begin
         tag_v <= '0;
      end else if (advance) begin
         tag_v[1] <= issue;
         for (int k = 2; k <= FWD_DEPTH; k++) begin
            tag_v[k] <= tag_v[k-1];
         end
      end
   end

   // NOTE: address and load fields are meaningless unless tag_v is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (advance) begin
         tag_addr[1] <= id_dst_addr;
         tag_ld[1]   <= id_is_load;
         for (int k = 2; k <= FWD_DEPTH; k++) begin
            tag_addr[k] <= tag_addr[k-1];
            tag_ld[k]   <= tag_ld[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && advance && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: three parameterisations checked every cycle against an issue-history
// model, plus directed scenarios with hand-computed expectations.
module tb_hazard_forward_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   typedef struct packed {
      logic            valid;
      logic [2:0][4:0] src;
      logic [2:0]      used;
      logic [4:0]      dst;
      logic            regwr;
      logic            ld;
      logic            flush;
   } in_t;

   in_t        drv [3];
   logic [2:0] hold;

   localparam int NS  [3] = '{2, 3, 1};
   localparam int DEP [3] = '{3, 4, 31};
   localparam int LR  [3] = '{2, 3, 31};

   logic [3:0]  a_sel;  logic a_stall;  logic [15:0] a_cnt;
   logic [8:0]  b_sel;  logic b_stall;  logic [15:0] b_cnt;
   logic [4:0]  c_sel;  logic c_stall;  logic [15:0] c_cnt;

   hazard_forward_ctrl #(.AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_READY(2)) u_a (
      .clk(clk), .reset(reset), .id_valid(drv[0].valid), .id_src_addr(drv[0].src[1:0]),
      .id_src_used(drv[0].used[1:0]), .id_dst_addr(drv[0].dst), .id_regwr(drv[0].regwr),
      .id_is_load(drv[0].ld), .id_flush(drv[0].flush), .pipe_hold(hold[0]),
      .fwd_sel(a_sel), .stall(a_stall), .stall_count(a_cnt));

   hazard_forward_ctrl #(.AW(5), .NUM_SRC(3), .FWD_DEPTH(4), .LOAD_READY(3)) u_b (
      .clk(clk), .reset(reset), .id_valid(drv[1].valid), .id_src_addr(drv[1].src),
      .id_src_used(drv[1].used), .id_dst_addr(drv[1].dst), .id_regwr(drv[1].regwr),
      .id_is_load(drv[1].ld), .id_flush(drv[1].flush), .pipe_hold(hold[1]),
      .fwd_sel(b_sel), .stall(b_stall), .stall_count(b_cnt));

   hazard_forward_ctrl #(.AW(5), .NUM_SRC(1), .FWD_DEPTH(31), .LOAD_READY(31)) u_c (
      .clk(clk), .reset(reset), .id_valid(drv[2].valid), .id_src_addr(drv[2].src[0]),
      .id_src_used(drv[2].used[0:0]), .id_dst_addr(drv[2].dst), .id_regwr(drv[2].regwr),
      .id_is_load(drv[2].ld), .id_flush(drv[2].flush), .pipe_hold(hold[2]),
      .fwd_sel(c_sel), .stall(c_stall), .stall_count(c_cnt));

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_model(string what, int n, int i, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL model_%s inst%0d src%0d at %0t: got %0d, expected %0d",
                    what, n, i, $time, act, exp);
   endtask

   function automatic int dut_sel(int n, int i);
      case (n)
         0:       return int'(a_sel[i*2 +: 2]);
         1:       return int'(b_sel[i*3 +: 3]);
         default: return int'(c_sel);
      endcase
   endfunction

   function automatic int dut_stall(int n);
      case (n)
         0:       return int'(a_stall);
         1:       return int'(b_stall);
         default: return int'(c_stall);
      endcase
   endfunction

   function automatic int dut_cnt(int n);
      case (n)
         0:       return int'(a_cnt);
         1:       return int'(b_cnt);
         default: return int'(c_cnt);
      endcase
   endfunction

   // Model: history of what each instance actually issued, indexed by age in cycles.
   bit         hv [3][1:31];
   logic [4:0] ha [3][1:31];
   bit         hl [3][1:31];
   int         mcnt [3];
   int         exp_sel [3][3];
   bit         exp_stall [3];
   bit         model_ready = 1'b0;

   task automatic model_eval(input int n);
      bit haz = 1'b0;
      for (int i = 0; i < 3; i++) exp_sel[n][i] = 0;
      for (int i = 0; i < NS[n]; i++) begin
         if (drv[n].used[i] && drv[n].src[i] != 5'd0) begin
            for (int age = 1; age <= DEP[n]; age++) begin
               if (exp_sel[n][i] == 0 && hv[n][age] && ha[n][age] == drv[n].src[i]) begin
                  exp_sel[n][i] = age;
                  if (hl[n][age] && age < LR[n]) haz = 1'b1;
               end
            end
         end
      end
      exp_stall[n] = drv[n].valid && !drv[n].flush && haz;
   endtask

   always @(posedge clk) begin
      for (int n = 0; n < 3; n++) begin
         model_eval(n);
         if (reset) begin
            for (int age = 1; age <= 31; age++) hv[n][age] = 1'b0;
            mcnt[n] = 0;
         end else if (!hold[n]) begin
            for (int age = 31; age >= 2; age--) begin
               hv[n][age] = hv[n][age-1];
               ha[n][age] = ha[n][age-1];
               hl[n][age] = hl[n][age-1];
            end
            hv[n][1] = drv[n].valid && !drv[n].flush && !exp_stall[n]
                       && drv[n].regwr && drv[n].dst != 5'd0;
            ha[n][1] = drv[n].dst;
            hl[n][1] = drv[n].ld;
            if (exp_stall[n] && mcnt[n] < 65535) mcnt[n]++;
         end
      end
      if (reset) model_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (model_ready) begin
         for (int n = 0; n < 3; n++) begin
            model_eval(n);
            for (int i = 0; i < NS[n]; i++) check_model("fwd_sel", n, i, dut_sel(n, i), exp_sel[n][i]);
            check_model("stall", n, 0, dut_stall(n), int'(exp_stall[n]));
            check_model("stall_count", n, 0, dut_cnt(n), mcnt[n]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(int n, bit v, int s0, int s1, int s2, bit [2:0] used,
                         int dst, bit wr, bit ld, bit fl);
      drv[n].valid  = v;
      drv[n].src[0] = 5'(s0);
      drv[n].src[1] = 5'(s1);
      drv[n].src[2] = 5'(s2);
      drv[n].used   = used;
      drv[n].dst    = 5'(dst);
      drv[n].regwr  = wr;
      drv[n].ld     = ld;
      drv[n].flush  = fl;
   endtask

   task automatic alu(int n, int dst, int s0, int s1);
      set_in(n, 1'b1, s0, s1, 0, 3'b011, dst, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic lw(int n, int dst, int base);
      set_in(n, 1'b1, base, 0, 0, 3'b001, dst, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic idle(int n);
      set_in(n, 1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      hold  = '0;
      for (int n = 0; n < 3; n++) idle(n);
      tick();
      tick();
      check("reset_sel", int'(a_sel), 0);
      check("reset_stall", int'(a_stall), 0);
      check("reset_count", int'(a_cnt), 0);
      reset = 1'b0;

      // ALU chain with 0..3 unrelated instructions between producer and consumer
      for (int gap = 0; gap <= 3; gap++) begin
         alu(0, 3, 1, 2);
         tick();
         for (int g = 0; g < gap; g++) begin
            alu(0, 9, 10, 11);
            tick();
         end
         alu(0, 5, 3, 4);
         #1;
         check($sformatf("alu_gap%0d_src0", gap), dut_sel(0, 0), (gap == 3) ? 0 : gap + 1);
         check($sformatf("alu_gap%0d_src1", gap), dut_sel(0, 1), 0);
         tick();
      end

      // Load-use: one bubble, then forward from stage 2
      lw(0, 7, 1);
      tick();
      alu(0, 8, 7, 7);
      #1;
      check("lu_stall", int'(a_stall), 1);
      tick();
      #1;
      check("lu_resolved_stall", int'(a_stall), 0);
      check("lu_src0", dut_sel(0, 0), 2);
      check("lu_src1", dut_sel(0, 1), 2);
      check("lu_count", int'(a_cnt), 1);
      tick();
      idle(0);
      tick(); tick(); tick();

      // Same pair with the consumer flushed
      lw(0, 7, 1);
      tick();
      alu(0, 8, 7, 7);
      drv[0].flush = 1'b1;
      #1;
      check("flush_stall", int'(a_stall), 0);
      tick();
      idle(0);
      #1;
      check("flush_count", int'(a_cnt), 1);
      tick(); tick(); tick();

      // Youngest producer wins; register 0 never forwards or stalls
      alu(0, 4, 1, 2);  tick();
      alu(0, 9, 10, 11); tick();
      alu(0, 4, 1, 2);  tick();
      alu(0, 6, 4, 0);
      #1;
      check("prio_src0", dut_sel(0, 0), 1);
      check("prio_src1_r0", dut_sel(0, 1), 0);
      tick();
      alu(0, 0, 1, 2); tick();
      alu(0, 6, 0, 0);
      #1;
      check("r0_src0", dut_sel(0, 0), 0);
      tick();
      lw(0, 0, 1); tick();
      alu(0, 6, 0, 0);
      #1;
      check("r0_load_stall", int'(a_stall), 0);
      tick();
      idle(0);
      tick(); tick(); tick();

      // Hold during a load-use stall
      lw(0, 7, 1);
      tick();
      alu(0, 8, 7, 7);
      hold[0] = 1'b1;
      for (int h = 0; h < 5; h++) begin
         tick();
         #1;
         check("hold_stall", int'(a_stall), 1);
         check("hold_count", int'(a_cnt), 1);
         check("hold_src0", dut_sel(0, 0), 1);
      end
      hold[0] = 1'b0;
      tick();
      #1;
      check("hold_release_count", int'(a_cnt), 2);
      check("hold_release_stall", int'(a_stall), 0);
      check("hold_release_src0", dut_sel(0, 0), 2);
      tick();
      idle(0);
      tick(); tick(); tick();

      // Reset mid-operation drops in-flight tags
      alu(0, 3, 1, 2);
      tick();
      alu(0, 5, 3, 4);
      reset = 1'b1;
      #1;
      check("prereset_src0", dut_sel(0, 0), 1);
      tick();
      reset = 1'b0;
      #1;
      check("postreset_src0", dut_sel(0, 0), 0);
      check("postreset_count", int'(a_cnt), 0);
      tick();
      idle(0);
      tick();

      // NUM_SRC=3, FWD_DEPTH=4, LOAD_READY=3: two bubbles, then stage 3
      lw(1, 6, 1);
      tick();
      set_in(1, 1'b1, 10, 11, 6, 3'b100, 8, 1'b1, 1'b0, 1'b0);
      #1;
      check("sweep_stall_1", int'(b_stall), 1);
      tick();
      #1;
      check("sweep_stall_2", int'(b_stall), 1);
      tick();
      #1;
      check("sweep_stall_3", int'(b_stall), 0);
      check("sweep_src2", dut_sel(1, 2), 3);
      check("sweep_count", int'(b_cnt), 2);
      tick();
      idle(1);
      tick();

      // Saturation: a self-dependent load re-issues every 31 cycles, stalling the other 30
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      set_in(2, 1'b1, 7, 0, 0, 3'b001, 7, 1'b1, 1'b1, 1'b0);
      repeat (62) tick();
      check("sat_early_count", int'(c_cnt), 60);
      repeat (72400 - 62) tick();
      check("sat_count", int'(c_cnt), 16'hFFFF);
      idle(2);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
